// File: rtl/cpu_pkg.sv
// Shared pipeline types and widths for the 16-bit core.
// No logic, so no latency; backpressure is not applicable.
// MEM_TIMEOUT_EN selects the MEM-stage watchdog elsewhere; nothing here depends on it.
package cpu_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int RD_W        = 4;
    localparam int MEM_TIMEOUT = 15;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    // Exactly one of read/write marks a real memory access; both set is illegal.
    function automatic logic is_mem_access(input logic rd_en, input logic wr_en);
        return rd_en ^ wr_en;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive REQ cycles and flags the TIMEOUT-th one (built only with MEM_TIMEOUT_EN).
// Latency: expired is combinational from the count, asserted in the TIMEOUT-th active cycle.
// Backpressure: none; the counter clears whenever active drops.
module mem_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = '0;
        if (active && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    // count_q holds the number of REQ cycles already completed.
    assign expired = active && (count_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: ALU results pass to writeback, loads/stores run a req/ready access (MEM_TIMEOUT_EN adds a watchdog).
// Latency: ALU op 1 cycle; an access finishing in REQ cycle k writes back k+1 cycles after acceptance.
// Backpressure: stall holds upstream from acceptance until mem_ready (or watchdog expiry).
module mem_access_stage #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_wre,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [RD_W-1:0]   ex_rd,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_wre,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    import cpu_pkg::*;

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              we_q, we_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_wre_q, wb_wre_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              err_q, err_d;
    logic              in_req;
    logic              timeout;

    assign in_req = (state_q == REQ);

`ifdef MEM_TIMEOUT_EN
    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_watchdog (
        .clk     (clk),
        .reset   (reset),
        .active  (in_req),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        we_d       = we_q;
        wb_valid_d = 1'b0;
        wb_wre_d   = 1'b0;
        wb_rd_d    = '0;
        wb_data_d  = '0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_mem_read && ex_mem_write) begin
                        // Illegal op retires as a non-writing slot so the pipeline keeps moving.
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        err_d      = 1'b1;
                    end else if (is_mem_access(ex_mem_read, ex_mem_write)) begin
                        state_d = REQ;
                        addr_d  = ex_alu_result[ADDR_W-1:0];
                        wdata_d = ex_store_data;
                        rd_d    = ex_rd;
                        we_d    = ex_mem_write;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_wre_d   = ex_wre;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_alu_result;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_wre_d   = !we_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = we_q ? '0 : mem_rdata;
                end else if (timeout) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    err_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall = (!in_req && ex_valid && is_mem_access(ex_mem_read, ex_mem_write))
                 || (in_req && !mem_ready && !timeout);

    // Request fields come straight from the latches and read as zero outside REQ.
    assign mem_req   = in_req;
    assign mem_we    = in_req && we_q;
    assign mem_addr  = in_req ? addr_q  : '0;
    assign mem_wdata = in_req ? wdata_q : '0;

    assign wb_valid = wb_valid_q;
    assign wb_wre   = wb_wre_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign err      = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_wre_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            wb_valid_q <= wb_valid_d;
            wb_wre_q   <= wb_wre_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage; timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_wre;
    logic [15:0] ex_alu_result, ex_store_data;
    logic [3:0]  ex_rd;
    logic        stall, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        wb_valid, wb_wre;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        err;

    typedef struct {
        logic        wre;
        logic [3:0]  rd;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .ADDR_W (16),
        .DATA_W (16),
        .RD_W   (4),
        .TIMEOUT(15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_wre       (ex_wre),
        .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data),
        .ex_rd        (ex_rd),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_wre       (wb_wre),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .err          (err)
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every valid writeback slot must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=0x%0h, expected no slot", wb_rd, wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_wre", 32'(wb_wre), 32'(e.wre));
                check("wb_err", 32'(err), 32'(e.err));
                if (!e.err) begin
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check("wb_data", 32'(wb_data), 32'(e.data));
                end
            end
        end else if (!reset && err) begin
            check("err_stray", 32'(err), 32'd0);
        end
    end

    task automatic drive_idle();
        ex_valid      = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_wre        = 1'b0;
        ex_alu_result = '0;
        ex_store_data = '0;
        ex_rd         = '0;
    endtask

    task automatic alu_op(input logic [15:0] d, input logic [3:0] rd, input logic wre);
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_wre = wre; ex_alu_result = d; ex_rd = rd;
        sb.push_back('{wre: wre, rd: rd, data: d, err: 1'b0});
        @(negedge clk);
        check("alu_stall", 32'(stall), 32'd0);
        check("alu_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        drive_idle();
    endtask

    // Accept a load/store, then answer it in REQ cycle k.
    task automatic do_access(input logic is_load, input logic [15:0] addr, input logic [15:0] wd,
                             input logic [3:0] rd, input int k, input logic [15:0] rdata);
        int stall_cnt;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_read = is_load; ex_mem_write = !is_load;
        ex_wre = is_load; ex_alu_result = addr; ex_store_data = wd; ex_rd = rd;
        mem_ready = 1'b0;
        sb.push_back('{wre: is_load, rd: rd, data: (is_load ? rdata : 16'h0), err: 1'b0});
        @(negedge clk);
        check("acc_stall_accept", 32'(stall), 32'd1);
        check("acc_req_accept", 32'(mem_req), 32'd0);
        stall_cnt = 32'(stall);
        for (int i = 1; i <= k; i++) begin
            @(posedge clk); #1;
            if (i == k) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            check("acc_mem_req", 32'(mem_req), 32'd1);
            check("acc_mem_we", 32'(mem_we), 32'(!is_load));
            check("acc_mem_addr", 32'(mem_addr), 32'(addr));
            if (!is_load) check("acc_mem_wdata", 32'(mem_wdata), 32'(wd));
            check("acc_stall_req", 32'(stall), 32'(i < k));
            stall_cnt += 32'(stall);
        end
        check("acc_stall_cycles", 32'(stall_cnt), 32'(k));
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        drive_idle();
        @(negedge clk);
        check("acc_req_done", 32'(mem_req), 32'd0);
        check("acc_addr_done", 32'(mem_addr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        alu_op(16'h1234, 4'd3, 1'b1);
        alu_op(16'h00FF, 4'd7, 1'b0);
        repeat (2) @(posedge clk);

        do_access(1'b1, 16'h0040, 16'h0000, 4'd5, 1, 16'hBEEF);
        do_access(1'b0, 16'h0010, 16'hA5A5, 4'd2, 4, 16'h0000);

        // Illegal op: both read and write.
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b1; ex_rd = 4'd9;
        ex_alu_result = 16'h0020; ex_wre = 1'b1;
        sb.push_back('{wre: 1'b0, rd: 4'd9, data: 16'h0, err: 1'b1});
        @(negedge clk);
        check("ill_mem_req", 32'(mem_req), 32'd0);
        check("ill_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check("ill_mem_req_after", 32'(mem_req), 32'd0);

        // Reset during the second REQ cycle.
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_result = 16'h0080; ex_rd = 4'd4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstreq_mem_req_before", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        drive_idle();
        sb.delete();
        #1;
        check("rstreq_mem_req", 32'(mem_req), 32'd0);
        check("rstreq_stall", 32'(stall), 32'd0);
        check("rstreq_wb_valid", 32'(wb_valid), 32'd0);
        check("rstreq_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_access(1'b1, 16'h0042, 16'h0000, 4'd6, 2, 16'h5A5A);

`ifdef MEM_TIMEOUT_EN
        begin
            int req_cnt;
            bit done;
            req_cnt = 0;
            done = 1'b0;
            @(posedge clk); #1;
            ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_result = 16'h0100; ex_rd = 4'd8;
            sb.push_back('{wre: 1'b0, rd: 4'd8, data: 16'h0, err: 1'b1});
            for (int c = 0; c < 40 && !done; c++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (mem_req) begin
                    req_cnt++;
                    check("to_stall", 32'(stall), 32'(req_cnt < 15));
                end else begin
                    done = 1'b1;
                end
            end
            check("to_req_cycles", 32'(req_cnt), 32'd15);
            check("to_done_in_bound", 32'(done), 32'd1);
            drive_idle();
        end
`endif

        alu_op(16'hCAFE, 4'd1, 1'b1);
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
